fm_modulate: RTL and testbench

//  FM modulator: AXI-Stream in/out, the transmit counterpart of the FM demodulator.

---
 rtl/fm_pkg.sv | 33 +++
 rtl/fm_modulate_if.sv | 13 +
 rtl/fm_modulate_core.sv | 111 +++++++++++
 rtl/quarter_sine_lut.sv | 40 ++++
 rtl/fm_modulate.sv | 56 +++++
 tb/tb_fm_modulate.sv | 272 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/fm_pkg.sv
// Shared FM modem types: phase/sample types, quarter-wave table geometry and
// the elaboration-time sine generator used to fill the quarter-wave ROM.
package fm_pkg;

  typedef logic [31:0]        phase_t;
  typedef logic signed [15:0] sample_t;

  localparam int unsigned LUT_ADDR_W = 10;
  localparam int unsigned QW_DEPTH   = 256;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // amp * sin(idx * (pi/2) / QW_DEPTH), rounded; Q30 Taylor series to x^15.
  function automatic logic [15:0] quarter_sine_entry(int unsigned idx, logic [15:0] amp);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (longint'(idx) * 64'sd1686629713) >>> 8;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int unsigned n = 1; n <= 7; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return 16'((sum * longint'(amp) + 64'sd536870912) >>> 30);
  endfunction

endpackage

// File: rtl/fm_modulate_if.sv
// AXI-Stream bundle used between the fm_modulate wrapper and its core.
interface fm_modulate_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;

  modport master (output tvalid, tlast, tdata, tstrb, input tready);
  modport slave  (input tvalid, tlast, tdata, tstrb, output tready);
endinterface

// File: rtl/fm_modulate_core.sv
// FM modulator datapath: phase accumulator plus a one-deep output register.
// Define FM_MODULATE_IQ_EN for cartesian {Q, I} output instead of polar.
module fm_modulate_core
  import fm_pkg::*;
#(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter phase_t      CARRIER_INC            = 32'h0,
  parameter int unsigned GAIN_SHIFT             = 4,
  parameter logic [15:0] AMPLITUDE              = 16'h7FFF,
  parameter int unsigned PHASE_CLR_ON_LAST      = 0
) (
  input logic            clk,
  input logic            rst_n,
  fm_modulate_if.slave   s_axis,
  fm_modulate_if.master  m_axis
);

  localparam int unsigned STRB_W = C_M00_AXIS_TDATA_WIDTH / 8;

  out_state_t                        state_q, state_d;
  phase_t                            phase_q, phase_d;
  phase_t                            inc;
  phase_t                            phase_n;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] word_n;
  logic                              tlast_q, tlast_d;
  logic [STRB_W-1:0]                 tstrb_q, tstrb_d;
  sample_t                           sample;
  logic signed [31:0]                dev;
  logic                              s_ready;
  logic                              accept;
  logic                              unused_hi;

  assign sample    = sample_t'(s_axis.tdata[15:0]);
  assign dev       = 32'(sample);
  assign inc       = CARRIER_INC + phase_t'(dev <<< GAIN_SHIFT);
  assign phase_n   = phase_q + inc;
  assign unused_hi = ^s_axis.tdata[C_S00_AXIS_TDATA_WIDTH-1:16];

`ifdef FM_MODULATE_IQ_EN
  logic signed [15:0] lut_sin;
  logic signed [15:0] lut_cos;

  quarter_sine_lut #(
    .AMPLITUDE (AMPLITUDE)
  ) u_lut (
    .addr  (phase_n[31:32-LUT_ADDR_W]),
    .sin_o (lut_sin),
    .cos_o (lut_cos)
  );

  always_comb begin
    word_n       = '0;
    word_n[31:0] = {lut_sin, lut_cos};
  end
`else
  always_comb begin
    word_n       = '0;
    word_n[31:0] = {phase_n[31:16], AMPLITUDE};
  end
`endif

  // Skid-free single register: refill is allowed in the same cycle it drains
  assign s_ready = m_axis.tready | (state_q == OUT_EMPTY);
  assign accept  = s_axis.tvalid & s_ready;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    tstrb_d = tstrb_q;

    case (state_q)
      OUT_EMPTY: if (accept) state_d = OUT_FULL;
      OUT_FULL:  if (m_axis.tready && !accept) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase

    if (accept) begin
      phase_d = (PHASE_CLR_ON_LAST != 0 && s_axis.tlast) ? '0 : phase_n;
      tdata_d = word_n;
      tlast_d = s_axis.tlast;
      tstrb_d = s_axis.tstrb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
      phase_q <= '0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
      tstrb_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
      tstrb_q <= tstrb_d;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = (state_q == OUT_FULL);
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tstrb  = tstrb_q;

endmodule

// File: rtl/quarter_sine_lut.sv
// Quarter-wave sine ROM with quadrant folding; combinational sin/cos for a
// LUT_ADDR_W-bit phase. Only instantiated when FM_MODULATE_IQ_EN is defined.
module quarter_sine_lut
  import fm_pkg::*;
#(
  parameter logic [15:0] AMPLITUDE = 16'h7FFF
) (
  input  logic [LUT_ADDR_W-1:0] addr,
  output logic signed [15:0]    sin_o,
  output logic signed [15:0]    cos_o
);

  logic [15:0]           rom [QW_DEPTH];
  logic [LUT_ADDR_W-1:0] qaddr [2];
  logic [8:0]            fold_idx [2];
  logic [15:0]           mag [2];
  logic signed [15:0]    val [2];

  for (genvar g = 0; g < QW_DEPTH; g++) begin : g_rom
    localparam logic [15:0] ENTRY = quarter_sine_entry(g, AMPLITUDE);
    assign rom[g] = ENTRY;
  end

  // cos is sin a quarter turn ahead; fold index 256 is the peak, not in the ROM
  assign qaddr[0] = addr;
  assign qaddr[1] = addr + 10'd256;

  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      fold_idx[k] = qaddr[k][8] ? (9'd256 - {1'b0, qaddr[k][7:0]})
                                : {1'b0, qaddr[k][7:0]};
      mag[k]      = fold_idx[k][8] ? AMPLITUDE : rom[fold_idx[k][7:0]];
      val[k]      = qaddr[k][9] ? -$signed(mag[k]) : $signed(mag[k]);
    end
  end

  assign sin_o = val[0];
  assign cos_o = val[1];

endmodule

// File: rtl/fm_modulate.sv
// FM modulator top: AXI-Stream samples in, phase words out (polar by default,
// {Q, I} when FM_MODULATE_IQ_EN is defined). Flat ports kept for drop-in use.
module fm_modulate
  import fm_pkg::*;
#(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter phase_t      CARRIER_INC            = 32'h0,
  parameter int unsigned GAIN_SHIFT             = 4,
  parameter logic [15:0] AMPLITUDE              = 16'h7FFF,
  parameter int unsigned PHASE_CLR_ON_LAST      = 0
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                s00_axis_tvalid,
  output logic                                s00_axis_tready,
  input  logic                                s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  output logic                                m00_axis_tvalid,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

  fm_modulate_if #(.DATA_W(C_S00_AXIS_TDATA_WIDTH)) s_if ();
  fm_modulate_if #(.DATA_W(C_M00_AXIS_TDATA_WIDTH)) m_if ();

  assign s_if.tvalid     = s00_axis_tvalid;
  assign s_if.tlast      = s00_axis_tlast;
  assign s_if.tdata      = s00_axis_tdata;
  assign s_if.tstrb      = s00_axis_tstrb;
  assign s00_axis_tready = s_if.tready;

  assign m_if.tready     = m00_axis_tready;
  assign m00_axis_tvalid = m_if.tvalid;
  assign m00_axis_tlast  = m_if.tlast;
  assign m00_axis_tdata  = m_if.tdata;
  assign m00_axis_tstrb  = m_if.tstrb;

  fm_modulate_core #(
    .C_S00_AXIS_TDATA_WIDTH (C_S00_AXIS_TDATA_WIDTH),
    .C_M00_AXIS_TDATA_WIDTH (C_M00_AXIS_TDATA_WIDTH),
    .CARRIER_INC            (CARRIER_INC),
    .GAIN_SHIFT             (GAIN_SHIFT),
    .AMPLITUDE              (AMPLITUDE),
    .PHASE_CLR_ON_LAST      (PHASE_CLR_ON_LAST)
  ) u_core (
    .clk    (s00_axis_aclk),
    .rst_n  (s00_axis_aresetn),
    .s_axis (s_if.slave),
    .m_axis (m_if.master)
  );

endmodule

// File: tb/tb_fm_modulate.sv
// Bench for fm_modulate: two differently configured instances share one input
// stream; a queue-based reference model predicts every output beat.
module tb_fm_modulate;

  localparam logic [31:0] CI_A  = 32'h0;
  localparam logic [31:0] CI_B  = 32'h4000_0000;
  localparam int          G_A   = 4;
  localparam int          G_B   = 2;
  localparam bit          CLR_A = 1'b1;
  localparam bit          CLR_B = 1'b0;
  localparam logic [15:0] AMP_A = 16'h7FFF;
  localparam logic [15:0] AMP_B = 16'h5A5A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_tready;
  logic b_s_tready;

  always #5 clk = ~clk;

  fm_modulate_if #(.DATA_W(32)) s_if ();
  fm_modulate_if #(.DATA_W(32)) ma_if ();
  fm_modulate_if #(.DATA_W(32)) mb_if ();

  assign ma_if.tready = m_tready;
  assign mb_if.tready = m_tready;

  fm_modulate #(
    .CARRIER_INC       (CI_A),
    .GAIN_SHIFT        (G_A),
    .AMPLITUDE         (AMP_A),
    .PHASE_CLR_ON_LAST (1)
  ) u_dut_a (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (s_if.tvalid),
    .s00_axis_tready  (s_if.tready),
    .s00_axis_tlast   (s_if.tlast),
    .s00_axis_tdata   (s_if.tdata),
    .s00_axis_tstrb   (s_if.tstrb),
    .m00_axis_tvalid  (ma_if.tvalid),
    .m00_axis_tready  (ma_if.tready),
    .m00_axis_tlast   (ma_if.tlast),
    .m00_axis_tdata   (ma_if.tdata),
    .m00_axis_tstrb   (ma_if.tstrb)
  );

  fm_modulate #(
    .CARRIER_INC       (CI_B),
    .GAIN_SHIFT        (G_B),
    .AMPLITUDE         (AMP_B),
    .PHASE_CLR_ON_LAST (0)
  ) u_dut_b (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (s_if.tvalid),
    .s00_axis_tready  (b_s_tready),
    .s00_axis_tlast   (s_if.tlast),
    .s00_axis_tdata   (s_if.tdata),
    .s00_axis_tstrb   (s_if.tstrb),
    .m00_axis_tvalid  (mb_if.tvalid),
    .m00_axis_tready  (mb_if.tready),
    .m00_axis_tlast   (mb_if.tlast),
    .m00_axis_tdata   (mb_if.tdata),
    .m00_axis_tstrb   (mb_if.tstrb)
  );

  typedef struct {
    logic [31:0] pa;
    logic [31:0] pb;
    logic        last;
    logic [3:0]  strb;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ph_a;
  logic [31:0] ph_b;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                     input int tol = 0);
    bit bad;
    int d;
    n_cmp++;
    if (tol == 0) begin
      bad = (obs !== exp);
    end else begin
      d   = int'(obs) - int'(exp);
      bad = (d > tol) || (d < -tol) || $isunknown(obs);
    end
    if (bad) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Frequency deviation in plain integer arithmetic, reduced mod 2^32
  function automatic logic [31:0] model_inc(input logic [31:0] ci, input int g,
                                            input logic [15:0] smp);
    longint s;
    s = longint'($signed(smp));
    return ci + 32'(s * (longint'(1) << g));
  endfunction

`ifdef FM_MODULATE_IQ_EN
  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction
`endif

  task automatic check_beat(input string nm, input logic [31:0] data, input logic last,
                            input logic [3:0] strb, input logic [31:0] ph,
                            input logic [15:0] amp, input exp_t e);
`ifdef FM_MODULATE_IQ_EN
    real ang;
    ang = 2.0 * 3.14159265358979 * real'(ph[31:22]) / 1024.0;
    chk({nm, "_i"}, 32'($signed(data[15:0])), 32'(rnd(real'(amp) * $cos(ang))), 1);
    chk({nm, "_q"}, 32'($signed(data[31:16])), 32'(rnd(real'(amp) * $sin(ang))), 1);
`else
    chk({nm, "_tdata"}, data, {ph[31:16], amp});
`endif
    chk({nm, "_tlast"}, 32'(last), 32'(e.last));
    chk({nm, "_tstrb"}, 32'(strb), 32'(e.strb));
  endtask

  task automatic monitor();
    bit ev;
    bit er;
    ev = (q.size() != 0);
    er = m_tready | !ev;
    chk("a_tvalid", 32'(ma_if.tvalid), 32'(ev));
    chk("b_tvalid", 32'(mb_if.tvalid), 32'(ev));
    chk("a_s_tready", 32'(s_if.tready), 32'(er));
    chk("b_s_tready", 32'(b_s_tready), 32'(er));
    if (ev) begin
      check_beat("a", ma_if.tdata, ma_if.tlast, ma_if.tstrb, q[0].pa, AMP_A, q[0]);
      check_beat("b", mb_if.tdata, mb_if.tlast, mb_if.tstrb, q[0].pb, AMP_B, q[0]);
      if (m_tready) void'(q.pop_front());
    end
  endtask

  task automatic push(input logic [15:0] d, input logic l, input logic [3:0] st);
    exp_t e;
    e.pa   = ph_a + model_inc(CI_A, G_A, d);
    e.pb   = ph_b + model_inc(CI_B, G_B, d);
    e.last = l;
    e.strb = st;
    ph_a   = (CLR_A && l) ? 32'h0 : e.pa;
    ph_b   = (CLR_B && l) ? 32'h0 : e.pb;
    q.push_back(e);
  endtask

  // One clock: drive at posedge+1, check at negedge, return whether a beat was accepted
  task automatic step(input logic v, input logic [15:0] d, input logic l,
                      input logic [3:0] st, input logic rdy, output bit acc);
    s_if.tvalid = v;
    s_if.tdata  = {16'($urandom), d};
    s_if.tlast  = l;
    s_if.tstrb  = st;
    m_tready    = rdy;
    @(negedge clk);
    monitor();
    acc = v && (s_if.tready === 1'b1);
    if (acc) push(d, l, st);
    @(posedge clk);
    #1;
  endtask

  task automatic send_n(input int n, input logic [15:0] d, input bit last_at_end);
    int sent;
    bit acc;
    sent = 0;
    for (int k = 0; k < n * 4 + 10 && sent < n; k++) begin
      step(1'b1, d, last_at_end && (sent == n - 1), 4'hF, 1'b1, acc);
      if (acc) sent++;
    end
    chk("send_count", 32'(sent), 32'(n));
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 8 && q.size() != 0; k++) step(1'b0, 16'h0, 1'b0, 4'h0, 1'b1, acc);
    step(1'b0, 16'h0, 1'b0, 4'h0, 1'b1, acc);
    chk("drained", 32'(q.size()), 32'h0);
  endtask

  task automatic reset_checks();
    chk("rst_a_tvalid", 32'(ma_if.tvalid), 32'h0);
    chk("rst_a_tdata", ma_if.tdata, 32'h0);
    chk("rst_a_tlast", 32'(ma_if.tlast), 32'h0);
    chk("rst_a_tstrb", 32'(ma_if.tstrb), 32'h0);
    chk("rst_b_tvalid", 32'(mb_if.tvalid), 32'h0);
    chk("rst_b_tdata", mb_if.tdata, 32'h0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 reset_checks();
    q.delete();
    ph_a        = 32'h0;
    ph_b        = 32'h0;
    s_if.tvalid = 1'b0;
    m_tready    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit acc;
    int cnt;
    logic [15:0] d;
    ph_a        = 32'h0;
    ph_b        = 32'h0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tstrb  = '0;
    m_tready    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_checks();
    rst_n = 1'b1;

    // Mid-packet reset with a beat held in the output register
    step(1'b1, 16'h0123, 1'b0, 4'h5, 1'b1, acc);
    step(1'b1, 16'h0456, 1'b0, 4'hA, 1'b0, acc);
    step(1'b1, 16'h0789, 1'b0, 4'h3, 1'b0, acc);
    do_reset();
    send_n(1, 16'h0000, 1'b0);
    drain();

    // Constant deviation, then zero-deviation carrier wrap
    do_reset();
    send_n(8, 16'h1000, 1'b0);
    drain();
    do_reset();
    send_n(5, 16'h0000, 1'b0);
    drain();

    // Backpressure then back-to-back throughput
    for (int k = 0; k < 5; k++) step(1'b1, 16'(16'h0100 * k), 1'b0, 4'hC, 1'b0, acc);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 16'(16'h0F00 + k), 1'b0, 4'h9, 1'b1, acc);
      if (acc) cnt++;
    end
    chk("b2b_accepts", 32'(cnt), 32'd10);
    drain();

    // Packet boundary: phase clear after tlast on instance A only
    do_reset();
    send_n(3, 16'h1000, 1'b1);
    send_n(1, 16'h1000, 1'b0);
    drain();

    // Randomized traffic including extreme samples
    for (int k = 0; k < 400; k++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 7) == 0) d = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
      step(1'b1 && ($urandom_range(0, 3) != 0), d, $urandom_range(0, 4) == 0,
           4'($urandom), $urandom_range(0, 2) != 0, acc);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
